// File: rtl/i2s_tx_sched.sv
// I2S transmit scheduler: a free-running phase counter derives MCLK/SCLK/LRCK,
// and a single-entry holding buffer feeds a frame register that is serialised
// MSB-first, one SCLK after each LRCK edge. Every output is registered and
// lags the phase counter by exactly one clk cycle.
module i2s_tx_sched #(
  parameter int MCLK_HALF = 4,
  parameter int SAMPLE_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  input  logic [SAMPLE_W-1:0] s_left,
  input  logic [SAMPLE_W-1:0] s_right,
  output logic                s_ready,
  output logic                mclk,
  output logic                sclk,
  output logic                lrck,
  output logic                sdata,
  output logic                frame_start,
  output logic                underrun
);

  localparam int L  = $clog2(MCLK_HALF);
  localparam int PW = L + 9;
  localparam logic [5:0] SW6 = 6'(SAMPLE_W);

  // Phase counter and data path state
  logic [PW-1:0]       phase_q, phase_d;
  logic                full_q, full_d;
  logic [SAMPLE_W-1:0] buf_l_q, buf_l_d;
  logic [SAMPLE_W-1:0] buf_r_q, buf_r_d;
  logic [SAMPLE_W-1:0] frm_l_q, frm_l_d;
  logic [SAMPLE_W-1:0] frm_r_q, frm_r_d;

  // Registered outputs
  logic s_ready_q, s_ready_d;
  logic mclk_q, mclk_d;
  logic sclk_q, sclk_d;
  logic lrck_q, lrck_d;
  logic sdata_q, sdata_d;
  logic frame_start_q, frame_start_d;
  logic underrun_q, underrun_d;

  // Decode helpers
  logic                load_s;
  logic                xfer_s;
  logic [4:0]          bit_k_s;
  logic                chan_s;
  logic [SAMPLE_W-1:0] cur_sample_s;
  logic [SAMPLE_W-1:0] shifted_s;
  logic                in_slot_s;

  // Phase advance, frame-load and handshake decode
  always_comb begin
    phase_d = phase_q + PW'(1);
    load_s  = (phase_q == {PW{1'b0}});
    xfer_s  = s_valid & s_ready_q;
  end

  // Holding buffer and frame register; a load empties the buffer before a
  // same-cycle transfer refills it, so a pair arriving at phase 0 is kept
  // for the following frame.
  always_comb begin
    full_d  = full_q;
    buf_l_d = buf_l_q;
    buf_r_d = buf_r_q;
    frm_l_d = frm_l_q;
    frm_r_d = frm_r_q;
    if (load_s) begin
      if (full_q) begin
        frm_l_d = buf_l_q;
        frm_r_d = buf_r_q;
        full_d  = 1'b0;
      end else begin
        frm_l_d = {SAMPLE_W{1'b0}};
        frm_r_d = {SAMPLE_W{1'b0}};
      end
    end else begin
      frm_l_d = frm_l_q;
      frm_r_d = frm_r_q;
    end
    if (xfer_s) begin
      buf_l_d = s_left;
      buf_r_d = s_right;
      full_d  = 1'b1;
    end else begin
      buf_l_d = buf_l_q;
      buf_r_d = buf_r_q;
    end
  end

  // Serial bit select: slot bit k carries sample bit SAMPLE_W-k, zero outside 1..SAMPLE_W
  always_comb begin
    bit_k_s      = phase_q[L+7:L+3];
    chan_s       = phase_q[L+8];
    cur_sample_s = chan_s ? frm_r_q : frm_l_q;
    shifted_s    = cur_sample_s >> (SW6 - {1'b0, bit_k_s});
    in_slot_s    = ({1'b0, bit_k_s} != 6'd0) && ({1'b0, bit_k_s} <= SW6);
    if (in_slot_s) begin
      sdata_d = shifted_s[0];
    end else begin
      sdata_d = 1'b0;
    end
  end

  // Output next-values, all taken from the current phase so they lag by one cycle
  always_comb begin
    mclk_d        = phase_q[L];
    sclk_d        = phase_q[L+2];
    lrck_d        = phase_q[L+8];
    frame_start_d = load_s;
    underrun_d    = load_s & ~full_q;
    s_ready_d     = ~full_d;
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_q       <= {PW{1'b0}};
      full_q        <= 1'b0;
      buf_l_q       <= {SAMPLE_W{1'b0}};
      buf_r_q       <= {SAMPLE_W{1'b0}};
      frm_l_q       <= {SAMPLE_W{1'b0}};
      frm_r_q       <= {SAMPLE_W{1'b0}};
      s_ready_q     <= 1'b0;
      mclk_q        <= 1'b0;
      sclk_q        <= 1'b0;
      lrck_q        <= 1'b0;
      sdata_q       <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      full_q        <= full_d;
      buf_l_q       <= buf_l_d;
      buf_r_q       <= buf_r_d;
      frm_l_q       <= frm_l_d;
      frm_r_q       <= frm_r_d;
      s_ready_q     <= s_ready_d;
      mclk_q        <= mclk_d;
      sclk_q        <= sclk_d;
      lrck_q        <= lrck_d;
      sdata_q       <= sdata_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  assign s_ready     = s_ready_q;
  assign mclk        = mclk_q;
  assign sclk        = sclk_q;
  assign lrck        = lrck_q;
  assign sdata       = sdata_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_i2s_tx_sched.sv
// Bench for i2s_tx_sched with default parameters (MCLK_HALF=4, SAMPLE_W=16,
// 2048-cycle frames). Stimulus pushes one expected frame per frame load into
// a queue; the monitor pops an entry on each frame_start and checks the
// underrun flag and all 64 slot bits of sdata.
module tb_i2s_tx_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic [15:0] s_left;
  logic [15:0] s_right;
  logic        s_ready;
  logic        mclk;
  logic        sclk;
  logic        lrck;
  logic        sdata;
  logic        frame_start;
  logic        underrun;

  i2s_tx_sched dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_left      (s_left),
    .s_right     (s_right),
    .s_ready     (s_ready),
    .mclk        (mclk),
    .sclk        (sclk),
    .lrck        (lrck),
    .sdata       (sdata),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
    logic        urun;
  } frame_t;

  frame_t exp_q[$];
  int total       = 0;
  int bad         = 0;
  int cyc         = 0;
  int frames_done = 0;
  int urun_seen   = 0;
  int urun_pushed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r, input logic u);
    frame_t f;
    f.l = l;
    f.r = r;
    f.urun = u;
    exp_q.push_back(f);
    if (u) urun_pushed++;
  endtask

  // Offer a pair and hold it until accepted; acc is the cycle of the handshake.
  task automatic send(input logic [15:0] l, input logic [15:0] r, input int budget, output int acc);
    s_valid = 1'b1;
    s_left  = l;
    s_right = r;
    acc     = -1;
    for (int i = 0; i < budget; i++) begin
      if (s_ready === 1'b1) begin
        acc = cyc;
        tick();
        break;
      end
      tick();
    end
    s_valid = 1'b0;
  endtask

  // Monitor: one expected frame per frame_start, sdata sampled mid-slot.
  initial begin : monitor
    frame_t      e;
    logic [63:0] got;
    bit          aborted;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && underrun === 1'b1) urun_seen++;
      if (rst === 1'b1 && frame_start === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL frame_unexpected: got frame_start at cyc=%0d expected none", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("frame_underrun", 64'(underrun), 64'(e.urun));
          got = 64'd0;
          aborted = 1'b0;
          for (int n = 1; n <= 2032; n++) begin
            @(negedge clk);
            if (rst !== 1'b1) begin
              aborted = 1'b1;
              break;
            end
            if (underrun === 1'b1) urun_seen++;
            if ((n % 32) == 16) got[63 - (n / 32)] = sdata;
          end
          if (!aborted) begin
            chk("frame_sdata", got, {1'b0, e.l, 15'd0, 1'b0, e.r, 15'd0});
            frames_done++;
          end
        end
      end
    end
  end

  // Directed stimulus
  initial begin : stim
    int acc;
    int me, se, le, de, uc, fc;
    rst     = 1'b0;
    s_valid = 1'b0;
    s_left  = 16'h0000;
    s_right = 16'h0000;
    push(16'h0000, 16'h0000, 1'b1);
    push(16'h0000, 16'h0000, 1'b1);
    push(16'h0000, 16'h0000, 1'b1);

    tick();
    tick();
    chk("reset_outputs_a", 64'({mclk, sclk, lrck, sdata, frame_start, underrun, s_ready}), 64'd0);
    tick();
    chk("reset_outputs_b", 64'({mclk, sclk, lrck, sdata, frame_start, underrun, s_ready}), 64'd0);

    rst = 1'b1;
    cyc = 0;
    chk("release_cycle0_outputs", 64'({mclk, sclk, lrck, sdata, frame_start, underrun, s_ready}), 64'd0);

    // Idle 4096 cycles: clocks follow the phase of the previous cycle.
    me = 0; se = 0; le = 0; de = 0; uc = 0; fc = 0;
    for (int c = 1; c <= 4096; c++) begin
      tick();
      if (c == 1) chk("s_ready_after_release", 64'(s_ready), 64'd1);
      if (mclk !== 1'(((c - 1) >> 2) & 1)) me++;
      if (sclk !== 1'(((c - 1) >> 4) & 1)) se++;
      if (lrck !== 1'(((c - 1) >> 10) & 1)) le++;
      if (sdata !== 1'b0) de++;
      if (underrun === 1'b1) uc++;
      if (frame_start === 1'b1) fc++;
    end
    chk("idle_mclk_errors", 64'(me), 64'd0);
    chk("idle_sclk_errors", 64'(se), 64'd0);
    chk("idle_lrck_errors", 64'(le), 64'd0);
    chk("idle_sdata_nonzero", 64'(de), 64'd0);
    chk("idle_underrun_pulses", 64'(uc), 64'd2);
    chk("idle_frame_start_pulses", 64'(fc), 64'd2);

    // Frame 3: known pattern
    goto(4200);
    push(16'hA5F0, 16'h0F0F, 1'b0);
    send(16'hA5F0, 16'h0F0F, 4, acc);
    chk("p0_accept", 64'(acc), 64'd4200);

    // Two pairs queued: second waits until the cycle after the next load
    goto(6200);
    push(16'h1234, 16'h8001, 1'b0);
    send(16'h1234, 16'h8001, 4, acc);
    chk("p1_accept", 64'(acc), 64'd6200);
    push(16'h7FFE, 16'hC3A5, 1'b0);
    send(16'h7FFE, 16'hC3A5, 2100, acc);
    chk("p2_accept_after_load", 64'(acc), 64'd8193);

    // Frame 6 skipped: underrun with silent frame, then normal play
    push(16'h0000, 16'h0000, 1'b1);
    goto(12388);
    push(16'h0001, 16'hFFFF, 1'b0);
    send(16'h0001, 16'hFFFF, 4, acc);
    chk("p3_accept", 64'(acc), 64'd12388);

    // Transfer exactly in the phase-0 cycle with the buffer empty
    goto(16384);
    push(16'h0000, 16'h0000, 1'b1);
    push(16'h8000, 16'h5555, 1'b0);
    chk("s_ready_at_phase0", 64'(s_ready), 64'd1);
    send(16'h8000, 16'h5555, 1, acc);
    chk("p4_accept_at_phase0", 64'(acc), 64'd16384);
    push(16'h0000, 16'h0000, 1'b1);

    // Fill the buffer, then reset at phase 700 of frame 10
    goto(20580);
    push(16'hDEAD, 16'hBEEF, 1'b0);
    send(16'hDEAD, 16'hBEEF, 4, acc);
    chk("p6_accept", 64'(acc), 64'd20580);
    goto(21180);
    chk("s_ready_full_before_reset", 64'(s_ready), 64'd0);
    rst = 1'b0;
    exp_q.delete();
    push(16'h0000, 16'h0000, 1'b1);
    push(16'h0000, 16'h0000, 1'b1);
    tick();
    rst = 1'b1;
    cyc = 0;
    chk("midframe_reset_outputs", 64'({mclk, sclk, lrck, sdata, frame_start, underrun, s_ready}), 64'd0);
    tick();
    chk("s_ready_after_midframe_reset", 64'(s_ready), 64'd1);

    while (frames_done < 12 && cyc < 4090) tick();
    chk("frames_completed", 64'(frames_done), 64'd12);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    chk("underrun_total", 64'(urun_seen), 64'(urun_pushed));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2s_tx_sched.md
I2S_TX_SCHED -- requirements
Module: i2s_tx_sched

Interface
REQ-001 Parameter MCLK_HALF, default 4, is the number of clk cycles per MCLK half-period; it SHALL be a power of two in {1,2,4,8}. Let L = log2(MCLK_HALF).
REQ-002 Parameter SAMPLE_W, default 16, is the sample width per channel; it SHALL be in range 1..31.
REQ-003 clk  input  1  system clock, 100 MHz.
REQ-004 rst  input  1  reset; one clock, synchronous, active-low (0 = reset).
REQ-005 s_valid  input  1  sample pair valid.
REQ-006 s_left  input  SAMPLE_W  left sample, two's complement.
REQ-007 s_right  input  SAMPLE_W  right sample, two's complement.
REQ-008 s_ready  output  1  holding buffer empty; can accept a sample pair.
REQ-009 mclk  output  1  codec master clock, clk/(2*MCLK_HALF).
REQ-010 sclk  output  1  serial bit clock, mclk/4.
REQ-011 lrck  output  1  word select, sclk/64; 0 = left, 1 = right.
REQ-012 sdata  output  1  I2S serial data.
REQ-013 frame_start  output  1  one-cycle pulse at each frame load.
REQ-014 underrun  output  1  one-cycle pulse when a frame load finds the buffer empty.

Function
REQ-015 Free-running counter phase, L+9 bits wide, SHALL increment by 1 every clk and wrap from all-ones to 0.
REQ-016 All outputs SHALL be registered; each SHALL reflect the phase value of the previous cycle (uniform 1-cycle lag).
REQ-017 mclk = phase[L], sclk = phase[L+2], lrck = phase[L+8]. With defaults: MCLK period 8 clk, SCLK period 32 clk, LRCK period 2048 clk.
REQ-018 Slot bit index k = phase[L+7:L+3] (0..31); channel = lrck.
REQ-019 sdata SHALL be sample[SAMPLE_W-k] of the current channel for k in 1..SAMPLE_W (MSB first, one SCLK after the LRCK edge), and 0 for k = 0 and k > SAMPLE_W.
REQ-020 sdata changes only on SCLK falling edges; lrck changes only on SCLK falling edges.
REQ-021 Holding buffer: one entry (left+right), with a full flag; s_ready SHALL equal the registered NOT full.
REQ-022 A transfer occurs when s_valid and s_ready are both 1 at a rising clk edge; the buffer captures s_left/s_right, and full is set the next cycle.
REQ-023 Frame load occurs in the cycle phase == 0. If full: the frame register takes the buffer, full clears, and frame_start pulses. If empty: the frame register loads zeros, frame_start pulses, and underrun pulses.
REQ-024 The frame register SHALL hold its value for the entire 2^(L+9)-cycle frame; mid-frame transfers SHALL NOT alter the current frame.
REQ-025 Simultaneous transfer and frame load (buffer empty): underrun is taken for this frame, and the transferred pair is stored for the next frame.
REQ-026 Buffer full at frame load with s_valid high: no transfer that cycle; s_ready rises the following cycle.
REQ-027 The block SHALL have no other states; no handshake deadlock is possible.

Reset
REQ-028 While rst = 0: phase = 0, full = 0, frame register = 0, and all outputs = 0 (including s_ready).
REQ-029 Reset asserted mid-frame SHALL take effect at the next edge; buffered and in-flight samples SHALL be discarded.
REQ-030 In the first cycle after release, phase = 0 triggers a frame load (empty, so underrun pulses), and outputs reflect phase 0 from the second cycle.

Verification
REQ-031 Reset, then idle 4096 cycles -> mclk period 8, sclk period 32, lrck period 2048 (low 1024, high 1024); sdata constantly 0; underrun pulses twice.
REQ-032 After release, write L=16'hA5F0, R=16'h0F0F -> frame 1: left slot bits 1..16 = 1010010111110000, right slot bits 1..16 = 0000111100001111; all other bits 0; frame_start pulses, no underrun.
REQ-033 Hold s_valid with two pairs queued -> first accepted immediately; s_ready stays 0 until cycle after the next phase==0; second accepted then and played in the following frame.
REQ-034 Skip one frame's write -> that frame's sdata is all 0, with exactly one underrun pulse; the next write plays normally.
REQ-035 Assert s_valid in exactly the phase==0 cycle with the buffer empty -> underrun pulses, and the pair plays in the next frame.
REQ-036 Assert rst for 1 cycle at phase 700 with the buffer full -> all outputs 0 next cycle, s_ready 0 then 1, and the old sample never appears on sdata.
